// File: rtl/instr_fetcher.sv
// Instruction fetcher: one outstanding icache request, next-pc from JAL/predicted branches, and a
// 2**QUEUE_WIDTH entry instruction queue. Define FETCH_STAT_EN to add fetch statistics counters.
module instr_fetcher #(
   parameter int unsigned LOCAL_WIDTH = 6,
   parameter int unsigned QUEUE_WIDTH = 3
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   output logic                   icache_req,
   output logic [31:0]            icache_addr,
   input  logic                   icache_valid,
   input  logic [31:0]            icache_instr,
   output logic [LOCAL_WIDTH-1:0] pred_addr,
   input  logic                   pred_jump,
   input  logic [1:0]             pred_sel,
   output logic                   iq_valid,
   output logic [31:0]            iq_instr,
   output logic [31:0]            iq_pc,
   output logic                   iq_pred_jump,
   output logic [1:0]             iq_pred_sel,
   input  logic                   iq_pop,
   input  logic                   flush,
   input  logic [31:0]            flush_pc
`ifdef FETCH_STAT_EN
   ,
   output logic [31:0]            stat_fetched,
   output logic [31:0]            stat_pred_taken
`endif
);

   localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;
   localparam logic [QUEUE_WIDTH:0] FULL_CNT = (QUEUE_WIDTH + 1)'(DEPTH);
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {StReq, StWait, StDrain} state_e;

   state_e                 r_state, w_state_next;
   logic [31:0]            r_pc, w_pc_next;
   logic [QUEUE_WIDTH-1:0] r_head, r_tail;
   logic [QUEUE_WIDTH:0]   r_count;
   logic [31:0]            r_q_instr [DEPTH];
   logic [31:0]            r_q_pc    [DEPTH];
   logic                   r_q_pj    [DEPTH];
   logic [1:0]             r_q_ps    [DEPTH];

   logic        w_full, w_push, w_pop, w_taken;
   logic [6:0]  w_opcode;
   logic [31:0] w_imm_j, w_imm_b;

   assign w_opcode = icache_instr[6:0];
   assign w_imm_j  = {{12{icache_instr[31]}}, icache_instr[19:12], icache_instr[20],
                      icache_instr[30:21], 1'b0};
   assign w_imm_b  = {{20{icache_instr[31]}}, icache_instr[7], icache_instr[30:25],
                      icache_instr[11:8], 1'b0};
   assign w_full   = (r_count == FULL_CNT);

   // JALR falls through to pc+4: its target is not known at fetch.
   always_comb begin
      w_taken   = 1'b0;
      w_pc_next = r_pc + 32'd4;
      if (w_opcode == OP_JAL) begin
         w_taken   = 1'b1;
         w_pc_next = r_pc + w_imm_j;
      end else if (w_opcode == OP_BRANCH && pred_jump) begin
         w_taken   = 1'b1;
         w_pc_next = r_pc + w_imm_b;
      end
   end

   always_comb begin
      w_state_next = r_state;
      icache_req   = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         StReq: begin
            if (!w_full && !flush) begin
               icache_req   = 1'b1;
               w_state_next = StWait;
            end
         end
         StWait: begin
            if (icache_valid) begin
               w_push       = !flush;
               w_state_next = StReq;
            end else if (flush) begin
               w_state_next = StDrain;
            end
         end
         StDrain: begin
            if (icache_valid) begin
               w_state_next = StReq;
            end
         end
         default: w_state_next = StReq;
      endcase
      if (rst_in || !rdy_in) begin
         icache_req = 1'b0;
         w_push     = 1'b0;
      end
   end

   assign w_pop = rdy_in && !rst_in && !flush && iq_pop && iq_valid;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= StReq;
         r_pc    <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy_in) begin
         r_state <= w_state_next;
         if (flush) begin
            r_pc    <= flush_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_pc   <= w_pc_next;
               r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
               r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_q_instr[r_tail] <= icache_instr;
         r_q_pc[r_tail]    <= r_pc;
         r_q_pj[r_tail]    <= pred_jump;
         r_q_ps[r_tail]    <= pred_sel;
      end
   end

   assign icache_addr  = r_pc;
   assign pred_addr    = r_pc[LOCAL_WIDTH+1:2];
   assign iq_valid     = (r_count != '0);
   assign iq_instr     = r_q_instr[r_head];
   assign iq_pc        = r_q_pc[r_head];
   assign iq_pred_jump = r_q_pj[r_head];
   assign iq_pred_sel  = r_q_ps[r_head];

`ifdef FETCH_STAT_EN
   logic [31:0] r_stat_fetched, r_stat_pred_taken;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_stat_fetched    <= '0;
         r_stat_pred_taken <= '0;
      end else if (w_push) begin
         r_stat_fetched <= r_stat_fetched + 32'd1;
         if (w_taken) begin
            r_stat_pred_taken <= r_stat_pred_taken + 32'd1;
         end
      end
   end

   assign stat_fetched    = r_stat_fetched;
   assign stat_pred_taken = r_stat_pred_taken;
`else
   logic w_unused_taken;
   assign w_unused_taken = w_taken;
`endif

endmodule

// File: doc/instr_fetcher.md
INSTR_FETCHER -- requirements
Module: instr_fetcher

Interface
REQ-001 Parameter LOCAL_WIDTH, default 6, SHALL be the predictor index width.
REQ-002 Parameter QUEUE_WIDTH, default 3, SHALL set instruction-queue depth to 2**QUEUE_WIDTH entries.
REQ-003 Port clk_in, input, 1: the single system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_in, input, 1: reset, synchronous and active-high.
REQ-005 Port rdy_in, input, 1: when low, all state SHALL hold and no queue push/pop SHALL occur.
REQ-006 Port icache_req, output, 1: one-cycle fetch request pulse.
REQ-007 Port icache_addr, output, 32: fetch PC, valid while icache_req=1.
REQ-008 Port icache_valid, input, 1: response strobe for the single outstanding request.
REQ-009 Port icache_instr, input, 32: fetched instruction, valid with icache_valid.
REQ-010 Port pred_addr, output, LOCAL_WIDTH: combinational, equals the fetch PC bits [LOCAL_WIDTH+1:2].
REQ-011 Port pred_jump, input, 1: predictor taken bit for pred_addr.
REQ-012 Port pred_sel, input, 2: predictor history selection for pred_addr.
REQ-013 Port iq_valid, output, 1: queue non-empty.
REQ-014 Port iq_instr / iq_pc, output, 32 each: head entry instruction and PC.
REQ-015 Port iq_pred_jump / iq_pred_sel, output, 1 / 2: head entry prediction snapshot, needed later for predictor update.
REQ-016 Port iq_pop, input, 1: consumer removes head this cycle.
REQ-017 Port flush, input, 1: mispredict/redirect.
REQ-018 Port flush_pc, input, 32: redirect target.

Function
REQ-019 FSM states SHALL be REQ, WAIT, DRAIN.
REQ-020 In REQ, if occupancy < depth and flush=0, icache_req SHALL pulse for one cycle with icache_addr=pc, and the next state SHALL be WAIT; otherwise the FSM SHALL stay in REQ.
REQ-021 In WAIT with icache_valid=1 and flush=0, the block SHALL push {icache_instr, pc, pred_jump, pred_sel} and update pc per REQ-022, and the next state SHALL be REQ.
REQ-022 Next pc rules: opcode 1101111 (JAL) -> pc+imm_J; opcode 1100011 (B-type) -> pred_jump ? pc+imm_B : pc+4; all others, including JALR -> pc+4; immediates sign-extended, 32-bit wraparound.
REQ-023 Fetch throughput SHALL be at most one instruction per two cycles; response latency from icache is unbounded.
REQ-024 Pop SHALL take effect only when iq_valid=1; pop while empty SHALL be ignored.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged, including when the queue is full.
REQ-026 Head/tail pointers SHALL wrap modulo depth.
REQ-027 On flush: the queue SHALL be emptied, pc<=flush_pc, and the same-cycle push/pop SHALL be discarded; from REQ or WAIT-with-icache_valid the next state SHALL be REQ; from WAIT without icache_valid the next state SHALL be DRAIN.
REQ-028 In DRAIN, icache_valid SHALL be discarded and the FSM SHALL move to REQ; a further flush SHALL update pc while remaining in DRAIN.

Reset
REQ-029 On rst_in=1: pc=0, queue empty, iq_valid=0, icache_req=0, state REQ; rst_in SHALL override rdy_in and flush.
REQ-030 Reset mid-WAIT SHALL drop the outstanding request; the cache is reset by the same signal.

Configuration
REQ-031 With macro FETCH_STAT_EN defined: outputs stat_fetched (32-bit) and stat_pred_taken (32-bit) SHALL count accepted pushes and pushes with a taken next-pc, both reset to 0 and wrapping.
REQ-032 Without FETCH_STAT_EN, these ports and counters SHALL be absent, with function otherwise identical.

Verification
REQ-033 Reset, then icache returns 0x00000013 after 1 cycle: icache_addr=0 then 4, iq_pc=0, iq_valid=1.
REQ-034 pc=0x10, instr 0x0080006F (JAL +8) -> next icache_addr=0x18.
REQ-035 pc=0x20, B-type imm=-8, pred_jump=1, pred_sel=2 -> next addr 0x18, iq_pred_sel=2; with pred_jump=0 -> next addr 0x24.
REQ-036 With no pops, 8 responses fill the queue: icache_req SHALL stay 0 until iq_pop; push+pop at full SHALL keep occupancy at 8.
REQ-037 Flush with flush_pc=0x100 in WAIT, stale icache_valid 3 cycles later -> stale data not queued, iq_valid=0, next icache_addr=0x100.
REQ-038 rdy_in=0 for 5 cycles during WAIT with icache_valid held -> no state change; push occurs on the first rdy_in=1 cycle.
